network_driver: RTL and testbench
=================================

NETWORK_DRIVER -- requirements
Module: network_driver

Interface
REQ-001 Parameters SHALL be:
- DATA_W, 100: width of network samples and result.
- N_IN, 9: samples per inference.
- TIMEOUT, 1023: WAIT cycles before abort.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock; all logic on rising edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: sample offered.
- in_ready, out, 1: sample accepted when in_valid && in_ready.
- in_data, in, DATA_W signed: serial sample.
- net_input_0..net_input_8, out, DATA_W signed each: parallel operands to network.
- net_start, out, 1: one-cycle inference start pulse.
- net_end, in, 1: network completion (level; rising edge is meaningful).
- net_out, in, DATA_W signed: network result.
- res_valid, out, 1: result available.
- res_ready, in, 1: result consumed when res_valid && res_ready.
- res_data, out, DATA_W signed: captured result.
- res_timeout, out, 1: result aborted by timeout (qualified by res_valid).
- busy, out, 1: high in FIRE or WAIT.
REQ-003 Clock and reset SHALL be: one clock, clk; reset rst synchronous and active-high.

Function
REQ-004 FSM SHALL have states COLLECT, FIRE, WAIT, DONE; reset state COLLECT.
REQ-005 COLLECT SHALL work as follows:
- in_ready=1.
- Each accepted sample SHALL be written to buffer[cnt], then cnt increments.
- cnt is 4 bits, range 0..8.
- Acceptance with cnt==8 SHALL move to FIRE and clear cnt.
REQ-006 in_ready SHALL be 0 in FIRE, WAIT and DONE; in_valid there SHALL be ignored and nothing written.
REQ-007 net_input_k SHALL be driven directly from buffer[k].
REQ-008 buffer SHALL change only on accepts in COLLECT, so operands stay stable from FIRE through DONE.
REQ-009 FIRE SHALL last exactly one cycle:
- net_start=1 in that cycle only.
- Next state WAIT; wait timer cleared to 0.
REQ-010 end_q SHALL be a register of net_end, updated every cycle.
REQ-011 Completion SHALL be detected as net_end && !end_q.
REQ-012 net_end already high on WAIT entry SHALL NOT count as completion.
REQ-013 On completion in WAIT, in the same edge:
- res_data <= net_out.
- res_timeout <= 0.
- go to DONE.
REQ-014 If no completion in WAIT, the timer SHALL increment.
REQ-015 When the timer reaches TIMEOUT-1 without completion:
- res_data <= 0.
- res_timeout <= 1.
- go to DONE.
REQ-016 Completion and timer expiry in the same cycle SHALL resolve as completion (timeout=0).
REQ-017 DONE SHALL work as follows:
- res_valid=1.
- res_data and res_timeout held stable.
- On res_ready: res_valid drops next cycle, state returns to COLLECT.
REQ-018 res_valid SHALL be 1 only in DONE; busy SHALL be 1 only in FIRE and WAIT.
REQ-019 Latency SHALL be:
- 9th accept at edge N → net_start high in cycle N+1.
- Completion edge seen at edge M → res_valid high in cycle M+1.
REQ-020 No arithmetic SHALL be performed on data; samples and result SHALL pass bit-exact, signed, full DATA_W.

Reset
REQ-021 On rst=1 at a clock edge, regardless of state:
- state=COLLECT, cnt=0, timer=0, end_q=0.
- all buffer entries=0 and net_input_0..8=0.
- res_data=0, res_timeout=0, res_valid=0.
- net_start=0, busy=0.
- in_ready=1 from the first cycle after rst deasserts.
REQ-022 Reset during WAIT or DONE SHALL discard the pending inference and result; a later net_end edge SHALL have no effect until the next FIRE.

Verification
REQ-023 Basic inference: stream samples 1..9 back-to-back, net_end rises 5 cycles after net_start with net_out=-42. Required:
- net_input_k = k+1.
- exactly one net_start pulse.
- res_valid with res_data=-42, res_timeout=0.
REQ-024 Gapped input: in_valid toggling 1/0 across 18 cycles. Required:
- all 9 samples captured in order.
- net_start exactly one cycle after the 9th accept.
REQ-025 Stale end: net_end held high before FIRE, falls 2 cycles into WAIT, rises 3 cycles later. Required:
- only the later rise captures.
- res_timeout=0.
REQ-026 Timeout: TIMEOUT=16, net_end never rises. Required:
- res_valid after 16 WAIT cycles.
- res_data=0, res_timeout=1.
REQ-027 Backpressure and reset:
- res_ready=0 for 10 cycles: res_valid and res_data held, in_ready=0, extra in_valid samples ignored.
- rst pulsed in WAIT: all outputs zero, next net_end edge ignored, fresh 9-sample collection works.

Source files
------------

// File: rtl/network_driver.sv
// network_driver: collects serial samples, fires a parallel inference, captures result or timeout.
module network_driver #(
  parameter int DATA_W  = 100,
  parameter int N_IN    = 9,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic signed [DATA_W-1:0] net_input_0,
  output logic signed [DATA_W-1:0] net_input_1,
  output logic signed [DATA_W-1:0] net_input_2,
  output logic signed [DATA_W-1:0] net_input_3,
  output logic signed [DATA_W-1:0] net_input_4,
  output logic signed [DATA_W-1:0] net_input_5,
  output logic signed [DATA_W-1:0] net_input_6,
  output logic signed [DATA_W-1:0] net_input_7,
  output logic signed [DATA_W-1:0] net_input_8,
  output logic                     net_start,
  input  logic                     net_end,
  input  logic signed [DATA_W-1:0] net_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [DATA_W-1:0] res_data,
  output logic                     res_timeout,
  output logic                     busy
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {COLLECT, FIRE, WAIT, DONE} state_t;
  state_t                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic                      end_q;
  logic signed [DATA_W-1:0]  buffer_q [N_IN];
  logic signed [DATA_W-1:0]  buffer_d [N_IN];
  logic signed [DATA_W-1:0]  res_data_q, res_data_d;
  logic                      res_timeout_q, res_timeout_d;
  logic                      accept, last, end_rise, expired;
  assign accept   = in_valid && state_q == COLLECT;
  assign last     = cnt_q == 4'(N_IN - 1);
  // A level already high when WAIT begins is not a completion; only a fresh rise counts.
  assign end_rise = net_end && !end_q;
  assign expired  = timer_q == TW'(TIMEOUT - 1);
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    timer_d       = timer_q;
    buffer_d      = buffer_q;
    res_data_d    = res_data_q;
    res_timeout_d = res_timeout_q;
    case (state_q)
      COLLECT: if (accept) begin
        for (int k = 0; k < N_IN; k++) if (cnt_q == 4'(k)) buffer_d[k] = in_data;
        cnt_d   = last ? 4'd0 : cnt_q + 4'd1;
        state_d = last ? FIRE : COLLECT;
      end
      FIRE: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: begin
        state_d       = (end_rise || expired) ? DONE : WAIT;
        timer_d       = (end_rise || expired) ? timer_q : timer_q + 1'b1;
        res_data_d    = end_rise ? net_out : expired ? '0 : res_data_q;
        res_timeout_d = end_rise ? 1'b0 : expired ? 1'b1 : res_timeout_q;
      end
      default: state_d = res_ready ? COLLECT : DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= COLLECT;
      cnt_q         <= '0;
      timer_q       <= '0;
      end_q         <= 1'b0;
      buffer_q      <= '{default: '0};
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      timer_q       <= timer_d;
      end_q         <= net_end;
      buffer_q      <= buffer_d;
      res_data_q    <= res_data_d;
      res_timeout_q <= res_timeout_d;
    end
  end
  assign in_ready    = state_q == COLLECT;
  assign net_start   = state_q == FIRE;
  assign busy        = state_q == FIRE || state_q == WAIT;
  assign res_valid   = state_q == DONE;
  assign res_data    = res_data_q;
  assign res_timeout = res_timeout_q;
  assign net_input_0 = buffer_q[0];
  assign net_input_1 = buffer_q[1];
  assign net_input_2 = buffer_q[2];
  assign net_input_3 = buffer_q[3];
  assign net_input_4 = buffer_q[4];
  assign net_input_5 = buffer_q[5];
  assign net_input_6 = buffer_q[6];
  assign net_input_7 = buffer_q[7];
  assign net_input_8 = buffer_q[8];
endmodule

// File: tb/tb_network_driver.sv
// tb_network_driver: directed scoreboard bench for network_driver with a short timeout.
module tb_network_driver;
  localparam int W = 100;
  typedef struct {
    logic signed [W-1:0] d;
    logic                t;
  } res_t;
  logic clk = 0, rst = 1, in_valid = 0, net_end = 0, res_ready = 0;
  logic signed [W-1:0] in_data = '0, net_out = '0;
  logic in_ready, net_start, res_valid, res_timeout, busy;
  logic signed [W-1:0] res_data;
  logic signed [W-1:0] ni [9];
  res_t sb [$];
  int n_checks = 0, n_fail = 0, starts = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (net_start) starts <= starts + 1;
  network_driver #(.DATA_W(W), .N_IN(9), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .net_input_0(ni[0]), .net_input_1(ni[1]), .net_input_2(ni[2]), .net_input_3(ni[3]),
    .net_input_4(ni[4]), .net_input_5(ni[5]), .net_input_6(ni[6]), .net_input_7(ni[7]),
    .net_input_8(ni[8]), .net_start(net_start), .net_end(net_end), .net_out(net_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_timeout(res_timeout), .busy(busy)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic signed [W-1:0] d, input logic t);
    res_t r;
    r.d = d;
    r.t = t;
    sb.push_back(r);
  endtask
  // Streams nine samples back to back, then steps one cycle past FIRE into WAIT.
  task automatic collect(input int base);
    int s0;
    logic signed [W-1:0] v;
    s0 = starts;
    for (int k = 0; k < 9; k++) begin
      in_valid = 1;
      in_data  = W'(base + k);
      tick;
    end
    in_valid = 0;
    check("start_after_9th", net_start, 1);
    check("ready_low_fire", in_ready, 0);
    check("busy_fire", busy, 1);
    for (int k = 0; k < 9; k++) begin
      v = W'(base + k);
      check($sformatf("net_input_%0d", k), ni[k], v);
    end
    tick;
    check("start_one_cycle", net_start, 0);
    check("start_count", starts, s0 + 1);
  endtask
  task automatic wait_result(input int limit);
    int n;
    res_t r;
    n = 0;
    while (!res_valid && n < limit) begin
      tick;
      n++;
    end
    check("res_valid_seen", res_valid, 1);
    if (sb.size() == 0) check("sb_nonempty", 0, 1);
    else begin
      r = sb.pop_front();
      check("res_data", res_data, r.d);
      check("res_timeout", res_timeout, r.t);
      check("busy_done", busy, 0);
    end
  endtask
  task automatic consume;
    res_ready = 1;
    tick;
    res_ready = 0;
    check("res_valid_dropped", res_valid, 0);
    check("ready_after_done", in_ready, 1);
  endtask
  initial begin
    logic signed [W-1:0] big;
    big = {4'h9, 32'hdeadbeef, 32'h01234567, 32'h89abcdef};
    tick;
    tick;
    rst = 0;
    check("rst_in_ready", in_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_net_start", net_start, 0);
    check("rst_res_data", res_data, 0);
    check("rst_net_input_8", ni[8], 0);
    // Basic inference: completion five cycles after the start pulse.
    collect(1);
    repeat (4) tick;
    net_end = 1;
    net_out = -42;
    push(-42, 0);
    tick;
    check("done_latency", res_valid, 1);
    wait_result(1);
    consume;
    net_end = 0;
    tick;
    // Gapped input: 9 accepts across 18 cycles.
    begin
      int s0;
      s0 = starts;
      for (int i = 0; i < 18; i++) begin
        in_valid = (i % 2 == 0);
        in_data  = (i % 2 == 0) ? W'(10 + i / 2) : W'(-1);
        tick;
        if (i == 16) check("gap_start_latency", net_start, 1);
      end
      in_valid = 0;
      for (int k = 0; k < 9; k++) check($sformatf("gap_input_%0d", k), ni[k], W'(10 + k));
      check("gap_start_count", starts, s0 + 1);
    end
    net_end = 1;
    net_out = big;
    push(big, 0);
    wait_result(20);
    repeat (3) tick;
    check("hold_unconsumed", res_valid, 1);
    consume;
    net_end = 0;
    // Stale end: high before FIRE, falls inside WAIT, later rise captures.
    net_end = 1;
    net_out = 555;
    collect(40);
    tick;
    net_end = 0;
    repeat (3) tick;
    check("stale_no_capture", res_valid, 0);
    check("stale_busy", busy, 1);
    net_end = 1;
    net_out = 777;
    push(777, 0);
    tick;
    check("stale_latency", res_valid, 1);
    wait_result(1);
    // Backpressure: result held while extra samples are refused.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1;
      in_data  = 999;
      tick;
      check("bp_valid", res_valid, 1);
      check("bp_data", res_data, 777);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 0;
    consume;
    check("bp_no_write", ni[0], 40);
    net_end = 0;
    // Timeout after 16 WAIT cycles; net_out must not leak into the result.
    net_out = 1234;
    collect(50);
    push(0, 1);
    repeat (15) tick;
    check("to_not_yet", res_valid, 0);
    tick;
    check("to_after_16", res_valid, 1);
    wait_result(1);
    consume;
    // Completion on the last timer cycle wins over expiry.
    collect(60);
    repeat (15) tick;
    net_end = 1;
    net_out = 321;
    push(321, 0);
    tick;
    wait_result(1);
    consume;
    net_end = 0;
    tick;
    // Reset during WAIT discards everything.
    collect(70);
    repeat (2) tick;
    rst = 1;
    tick;
    rst = 0;
    check("rw_res_valid", res_valid, 0);
    check("rw_busy", busy, 0);
    check("rw_in_ready", in_ready, 1);
    check("rw_res_data", res_data, 0);
    check("rw_res_timeout", res_timeout, 0);
    for (int k = 0; k < 9; k++) check($sformatf("rw_input_%0d", k), ni[k], 0);
    net_end = 1;
    net_out = 9;
    repeat (3) tick;
    check("rw_edge_ignored", res_valid, 0);
    check("rw_idle", busy, 0);
    net_end = 0;
    tick;
    collect(80);
    net_end = 1;
    net_out = -7;
    push(-7, 0);
    wait_result(20);
    consume;
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
